// File: rtl/arb_pkg.sv
// ============================================================================
// Module      : arb_pkg
// Description : Shared types and helpers for the priority_arbiter slice.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

package arb_pkg;

    localparam int MAX_N     = 16;
    localparam int MAX_IDX_W = 4;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_t;

    // Operand must be one-hot or zero; OR-ing indices keeps the logic flat.
    function automatic logic [MAX_IDX_W-1:0] onehot_to_idx(input logic [MAX_N-1:0] oh);
        logic [MAX_IDX_W-1:0] idx;
        idx = '0;
        for (int i = 0; i < MAX_N; i++) begin
            if (oh[i]) idx = idx | MAX_IDX_W'(i);
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/prio_pick.sv
// ============================================================================
// Module      : prio_pick
// Description : Combinational one-hot picker over (req & ~mask). Highest index
//               wins by default; with ARB_ROUND_ROBIN_EN the search starts at
//               index rot and moves upward, wrapping modulo N.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module prio_pick #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [N-1:0]     mask,
    input  logic [IDX_W-1:0] rot,
    output logic [N-1:0]     grant
);

    logic [N-1:0] cand;
    assign cand = req & ~mask;

`ifdef ARB_ROUND_ROBIN_EN
    logic [N-1:0] rotated;
    logic [N-1:0] pick_rot;

    // Rotating right by rot puts the search start at bit 0, so the lowest set bit wins.
    assign rotated  = N'({cand, cand} >> rot);
    assign pick_rot = rotated & (~rotated + N'(1));
    assign grant    = N'(({pick_rot, pick_rot} << rot) >> N);
`else
    logic unused_rot;
    assign unused_rot = ^rot;

    always_comb begin
        grant = '0;
        for (int i = 0; i < N; i++) begin
            if (cand[i]) grant = N'(1) << i;
        end
    end
`endif

endmodule

`default_nettype wire

// File: rtl/priority_arbiter.sv
// ============================================================================
// Module      : priority_arbiter
// Description : Registered N-way arbiter with hold timeout. Fixed priority
//               (highest index) by default; define ARB_ROUND_ROBIN_EN for
//               round-robin selection.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module priority_arbiter
    import arb_pkg::*;
#(
    parameter int N        = 4,
    parameter int MAX_HOLD = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [N-1:0]         req,
    output logic [N-1:0]         grant,
    output logic                 grant_vld,
    output logic [$clog2(N)-1:0] owner_id
);

    localparam int         IDX_W      = $clog2(N);
    localparam bit         TIMEOUT_EN = (MAX_HOLD != 0);
    localparam logic [7:0] HOLD_LAST  = (MAX_HOLD == 0) ? 8'd255 : 8'(MAX_HOLD - 1);

    arb_state_t           state;
    logic [7:0]           hold_cnt;
    logic                 release_own;
    logic                 timeout;
    logic                 take_new;
    logic                 go_idle;
    logic [N-1:0]         pick_mask;
    logic [N-1:0]         win;
    logic [MAX_N-1:0]     win_ext;
    logic [MAX_IDX_W-1:0] win_idx_full;
    logic [IDX_W-1:0]     win_idx;
    logic [IDX_W-1:0]     rot;
    logic                 unused_idx_hi;

    // grant is the owner's one-hot, so it doubles as the owner mask.
    assign release_own = ~|(req & grant);
    assign timeout     = TIMEOUT_EN && (hold_cnt == HOLD_LAST) && |(req & ~grant);
    assign pick_mask   = release_own ? '0 : grant;

    assign take_new = (|win) && ((state == IDLE) || release_own || timeout);
    assign go_idle  = (state == BUSY) && release_own && !(|win);

    always_comb begin
        win_ext        = '0;
        win_ext[N-1:0] = win;
    end

    assign win_idx_full  = onehot_to_idx(win_ext);
    assign win_idx       = win_idx_full[IDX_W-1:0];
    assign unused_idx_hi = ^win_idx_full;

`ifdef ARB_ROUND_ROBIN_EN
    logic [IDX_W-1:0] last_owner;
    assign rot = (last_owner == IDX_W'(N - 1)) ? '0 : last_owner + IDX_W'(1);
`else
    assign rot = '0;
`endif

    prio_pick #(
        .N     (N),
        .IDX_W (IDX_W)
    ) u_pick (
        .req   (req),
        .mask  (pick_mask),
        .rot   (rot),
        .grant (win)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            grant      <= '0;
            grant_vld  <= 1'b0;
            owner_id   <= '0;
            hold_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= IDX_W'(N - 1);
`endif
        end else if (take_new) begin
            state      <= BUSY;
            grant      <= win;
            grant_vld  <= 1'b1;
            owner_id   <= win_idx;
            hold_cnt   <= '0;
`ifdef ARB_ROUND_ROBIN_EN
            last_owner <= win_idx;
`endif
        end else if (go_idle) begin
            state     <= IDLE;
            grant     <= '0;
            grant_vld <= 1'b0;
            owner_id  <= '0;
            hold_cnt  <= '0;
        end else if ((state == BUSY) && (hold_cnt != HOLD_LAST)) begin
            // Saturating at HOLD_LAST lets a lone owner be pre-empted as soon as a rival shows up.
            hold_cnt <= hold_cnt + 8'd1;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_priority_arbiter.sv
// ============================================================================
// Module      : tb_priority_arbiter
// Description : Self-checking bench for priority_arbiter (N=4, MAX_HOLD=4)
//               against a behavioural arbitration model.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_priority_arbiter;

    localparam int N        = 4;
    localparam int MAX_HOLD = 4;
`ifdef ARB_ROUND_ROBIN_EN
    localparam logic [3:0] FIRST_GRANT = 4'b0001;
`else
    localparam logic [3:0] FIRST_GRANT = 4'b1000;
`endif

    logic       clk   = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] req   = '0;
    logic [3:0] grant;
    logic       grant_vld;
    logic [1:0] owner_id;

    int errors = 0;
    int checks = 0;

    // Model: owner index (-1 idle), cycles the owner has held, last granted index.
    int m_owner = -1;
    int m_held  = 0;
    int m_last  = N - 1;

    always #5 clk = ~clk;

    priority_arbiter #(
        .N        (N),
        .MAX_HOLD (MAX_HOLD)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .grant     (grant),
        .grant_vld (grant_vld),
        .owner_id  (owner_id)
    );

    function automatic int m_pick(input logic [3:0] r, input int excl);
`ifdef ARB_ROUND_ROBIN_EN
        for (int k = 1; k <= N; k++) begin
            int i;
            i = (m_last + k) % N;
            if (r[i] && i != excl) return i;
        end
`else
        for (int i = N - 1; i >= 0; i--) begin
            if (r[i] && i != excl) return i;
        end
`endif
        return -1;
    endfunction

    function automatic logic [6:0] exp_vec();
        logic [3:0] g;
        logic [1:0] id;
        g  = (m_owner < 0) ? 4'b0000 : (4'b0001 << m_owner);
        id = (m_owner < 0) ? 2'd0 : 2'(m_owner);
        return {g, (m_owner >= 0), id};
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_held  = 0;
        m_last  = N - 1;
    endtask

    task automatic model_take(input int w);
        m_owner = w;
        m_held  = 1;
        m_last  = w;
    endtask

    task automatic model_step(input logic [3:0] r);
        int w;
        if (m_owner < 0) begin
            w = m_pick(r, -1);
            if (w >= 0) model_take(w);
        end else if (!r[m_owner]) begin
            w = m_pick(r, -1);
            if (w >= 0) model_take(w);
            else begin
                m_owner = -1;
                m_held  = 0;
            end
        end else if (MAX_HOLD != 0 && m_held >= MAX_HOLD && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
            model_take(m_pick(r, m_owner));
        end else begin
            m_held++;
        end
    endtask

    task automatic apply(input logic [3:0] r);
        @(negedge clk);
        req = r;
        @(posedge clk);
        model_step(r);
        #1;
    endtask

    task automatic test_reset();
        logic [6:0] e;
        reset = 1'b1;
        req   = 4'b1111;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({grant, grant_vld, owner_id} !== 7'b0) begin
                errors++;
                $display("FAIL reset_hold: got grant=%b vld=%b id=%0d, expected 0000/0/0", grant, grant_vld, owner_id);
            end
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        apply(4'b1111);
        e = exp_vec();
        checks++;
        if ({grant, grant_vld, owner_id} !== e || grant !== FIRST_GRANT) begin
            errors++;
            $display("FAIL first_grant: got grant=%b vld=%b id=%0d, expected grant=%b vld=%b id=%0d",
                     grant, grant_vld, owner_id, FIRST_GRANT, e[2], e[1:0]);
        end
    endtask

    task automatic test_fixed_priority();
        logic [6:0] e;
        apply(4'b0110);
        e = exp_vec();
        checks++;
        if ({grant, grant_vld, owner_id} !== e) begin
            errors++;
            $display("FAIL prio_0110: got grant=%b vld=%b id=%0d, expected grant=%b vld=%b id=%0d",
                     grant, grant_vld, owner_id, e[6:3], e[2], e[1:0]);
        end
`ifndef ARB_ROUND_ROBIN_EN
        checks++;
        if (grant !== 4'b0100 || owner_id !== 2'd2) begin
            errors++;
            $display("FAIL prio_literal: got grant=%b id=%0d, expected grant=0100 id=2", grant, owner_id);
        end
`endif
        apply(4'b0010);
        e = exp_vec();
        checks++;
        if ({grant, grant_vld, owner_id} !== e || grant === 4'b0000) begin
            errors++;
            $display("FAIL prio_handover: got grant=%b vld=%b id=%0d, expected grant=%b vld=%b id=%0d",
                     grant, grant_vld, owner_id, e[6:3], e[2], e[1:0]);
        end
    endtask

    task automatic test_timeout();
        logic [6:0] e;
        apply(4'b0000);
        for (int c = 0; c < 13; c++) begin
            apply(4'b1001);
            e = exp_vec();
            checks++;
            if ({grant, grant_vld, owner_id} !== e) begin
                errors++;
                $display("FAIL timeout cyc%0d: got grant=%b vld=%b id=%0d, expected grant=%b vld=%b id=%0d",
                         c, grant, grant_vld, owner_id, e[6:3], e[2], e[1:0]);
            end
        end
    endtask

    task automatic test_lone_owner();
        logic [6:0] e;
        for (int c = 0; c < 20; c++) begin
            apply(4'b0100);
            checks++;
            if (grant !== 4'b0100 || grant_vld !== 1'b1 || owner_id !== 2'd2) begin
                errors++;
                $display("FAIL lone_owner cyc%0d: got grant=%b vld=%b id=%0d, expected grant=0100 vld=1 id=2",
                         c, grant, grant_vld, owner_id);
            end
        end
        // A rival arriving after saturation pre-empts on the very next edge.
        apply(4'b0110);
        e = exp_vec();
        checks++;
        if ({grant, grant_vld, owner_id} !== e) begin
            errors++;
            $display("FAIL lone_preempt: got grant=%b vld=%b id=%0d, expected grant=%b vld=%b id=%0d",
                     grant, grant_vld, owner_id, e[6:3], e[2], e[1:0]);
        end
    endtask

    task automatic test_release_to_empty();
        apply(4'b0000);
        checks++;
        if ({grant, grant_vld, owner_id} !== 7'b0) begin
            errors++;
            $display("FAIL release_idle: got grant=%b vld=%b id=%0d, expected 0000/0/0", grant, grant_vld, owner_id);
        end
        apply(4'b0001);
        checks++;
        if (grant !== 4'b0001 || grant_vld !== 1'b1 || owner_id !== 2'd0) begin
            errors++;
            $display("FAIL idle_to_grant: got grant=%b vld=%b id=%0d, expected grant=0001 vld=1 id=0",
                     grant, grant_vld, owner_id);
        end
    endtask

    task automatic test_reset_midgrant();
        apply(4'b1000);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({grant, grant_vld, owner_id} !== 7'b0) begin
            errors++;
            $display("FAIL async_reset: got grant=%b vld=%b id=%0d, expected 0000/0/0", grant, grant_vld, owner_id);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

`ifdef ARB_ROUND_ROBIN_EN
    task automatic test_round_robin();
        logic [3:0] seq [5];
        logic [6:0] e;
        seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        for (int k = 0; k < 5; k++) begin
            e = exp_vec();
            apply(4'b1111 & ~e[6:3]);
            e = exp_vec();
            checks++;
            if (grant !== seq[k] || {grant, grant_vld, owner_id} !== e) begin
                errors++;
                $display("FAIL rr_seq%0d: got grant=%b, expected grant=%b", k, grant, seq[k]);
            end
        end
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({grant, grant_vld, owner_id} !== 7'b0) begin
            errors++;
            $display("FAIL rr_reset: got grant=%b vld=%b id=%0d, expected 0000/0/0", grant, grant_vld, owner_id);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask
`endif

    task automatic test_random();
        logic [3:0] r;
        logic [6:0] e;
        r = 4'b0000;
        for (int c = 0; c < 400; c++) begin
            if ($urandom_range(3) == 0) r = 4'($urandom);
            apply(r);
            e = exp_vec();
            checks++;
            if ({grant, grant_vld, owner_id} !== e || !$onehot0(grant)) begin
                errors++;
                $display("FAIL random cyc%0d req=%b: got grant=%b vld=%b id=%0d, expected grant=%b vld=%b id=%0d",
                         c, r, grant, grant_vld, owner_id, e[6:3], e[2], e[1:0]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_fixed_priority();
        test_timeout();
        test_lone_owner();
        test_release_to_empty();
        test_reset_midgrant();
`ifdef ARB_ROUND_ROBIN_EN
        test_round_robin();
`endif
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
